// File: rtl/multi_channel_demux.sv
// multi_channel_demux: fans a TDM signed sample stream out to up to 12 parallel
// channel outputs (a..l). Samples collect in shadow registers and all channels
// publish together when the frame's last sample arrives.
// Optional: define CHANNEL_DEMUX_ERR_COUNT_EN to add a saturating 8-bit err_count port.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a frame-start sample (din_first)
// COLLECT | frame in progress, ch_idx is the next channel to capture

module multi_channel_demux #(
  parameter int DATA_BITS       = 12,
  parameter int ACTIVE_CHANNELS = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic signed [DATA_BITS-1:0] din,
  input  logic                        din_valid,
  input  logic                        din_first,
  output logic signed [DATA_BITS-1:0] a,
  output logic signed [DATA_BITS-1:0] b,
  output logic signed [DATA_BITS-1:0] c,
  output logic signed [DATA_BITS-1:0] d,
  output logic signed [DATA_BITS-1:0] e,
  output logic signed [DATA_BITS-1:0] f,
  output logic signed [DATA_BITS-1:0] g,
  output logic signed [DATA_BITS-1:0] h,
  output logic signed [DATA_BITS-1:0] i,
  output logic signed [DATA_BITS-1:0] j,
  output logic signed [DATA_BITS-1:0] k,
  output logic signed [DATA_BITS-1:0] l,
  output logic                        frame_strobe,
  output logic                        frame_error
`ifdef CHANNEL_DEMUX_ERR_COUNT_EN
  ,
  output logic [7:0]                  err_count
`endif
);

  localparam int         NCH      = 12;
  localparam logic [3:0] LAST_IDX = 4'(ACTIVE_CHANNELS - 1);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t     state, state_nxt;
  logic [3:0] ch_idx, ch_idx_nxt;
  logic [3:0] wr_idx;
  logic       wr_en;
  logic       publish;
  logic       err;

  logic signed [DATA_BITS-1:0] shadow [NCH];
  logic signed [DATA_BITS-1:0] out_q  [NCH];

  // state and channel index register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ch_idx <= '0;
    end else begin
      state  <= state_nxt;
      ch_idx <= ch_idx_nxt;
    end
  end

  // next-state, capture, publish and error decode
  always_comb begin
    state_nxt  = state;
    ch_idx_nxt = ch_idx;
    wr_idx     = ch_idx;
    wr_en      = 1'b0;
    publish    = 1'b0;
    err        = 1'b0;
    if (din_valid) begin
      if (din_first) begin
        // a frame start while collecting means the previous frame was short
        err    = (state == COLLECT);
        wr_en  = 1'b1;
        wr_idx = '0;
        if (ACTIVE_CHANNELS == 1) begin
          publish    = 1'b1;
          state_nxt  = IDLE;
          ch_idx_nxt = '0;
        end else begin
          state_nxt  = COLLECT;
          ch_idx_nxt = 4'd1;
        end
      end else if (state == COLLECT) begin
        wr_en = 1'b1;
        if (ch_idx == LAST_IDX) begin
          publish    = 1'b1;
          state_nxt  = IDLE;
          ch_idx_nxt = '0;
        end else begin
          ch_idx_nxt = ch_idx + 4'd1;
        end
      end else begin
        // sample without a frame start: dropped
        err = 1'b1;
      end
    end
  end

  // shadow capture of in-flight frame samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NCH; n++) shadow[n] <= '0;
    end else if (wr_en) begin
      shadow[wr_idx] <= din;
    end
  end

  // publish: last channel comes straight from din so outputs land one clock after it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NCH; n++) out_q[n] <= '0;
    end else if (publish) begin
      for (int n = 0; n < NCH; n++) begin
        if (n < ACTIVE_CHANNELS - 1)       out_q[n] <= shadow[n];
        else if (n == ACTIVE_CHANNELS - 1) out_q[n] <= din;
        else                               out_q[n] <= '0;
      end
    end
  end

  // one-cycle status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_strobe <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      frame_strobe <= publish;
      frame_error  <= err;
    end
  end

`ifdef CHANNEL_DEMUX_ERR_COUNT_EN
  // saturating count of error pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     err_count <= '0;
    else if (err && err_count != 8'hFF) err_count <= err_count + 8'd1;
  end
`endif

  assign a = out_q[0];
  assign b = out_q[1];
  assign c = out_q[2];
  assign d = out_q[3];
  assign e = out_q[4];
  assign f = out_q[5];
  assign g = out_q[6];
  assign h = out_q[7];
  assign i = out_q[8];
  assign j = out_q[9];
  assign k = out_q[10];
  assign l = out_q[11];

endmodule

// File: tb/tb_multi_channel_demux.sv
// Testbench for multi_channel_demux with ACTIVE_CHANNELS=4: directed frames plus
// random traffic against a frame-level reference model and an event scoreboard.
module tb_multi_channel_demux;

  localparam int N = 4;

  typedef struct packed {
    logic             is_err;
    logic [11:0][11:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic signed [11:0] din;
  logic din_valid, din_first;
  logic signed [11:0] a, b, c, d, e, f, g, h, i, j, k, l;
  logic frame_strobe, frame_error;
`ifdef CHANNEL_DEMUX_ERR_COUNT_EN
  logic [7:0] err_count;
`endif

  multi_channel_demux #(.DATA_BITS(12), .ACTIVE_CHANNELS(N)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_first(din_first),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h), .i(i), .j(j), .k(k), .l(l),
    .frame_strobe(frame_strobe), .frame_error(frame_error)
`ifdef CHANNEL_DEMUX_ERR_COUNT_EN
    , .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  logic [11:0][11:0] outs;
  assign outs = {l, k, j, i, h, g, f, e, d, c, b, a};

  int errors = 0;
  int checks = 0;
  exp_t exp_q[$];
  int cnt = 0;
  logic [11:0][11:0] part = '0;
  logic [11:0][11:0] last_pub = '0;
  int exp_errcnt = 0;

  task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // frame-level reference: a frame is one first-sample followed by N-1 more samples
  function automatic void model(input logic [11:0] dv, input bit fs);
    exp_t x;
    x.is_err = 1'b1;
    x.v      = '0;
    if (fs) begin
      if (cnt != 0) exp_q.push_back(x);
      part    = '0;
      part[0] = dv;
      cnt     = 1;
    end else if (cnt == 0) begin
      exp_q.push_back(x);
      return;
    end else begin
      part[cnt] = dv;
      cnt++;
    end
    if (cnt == N) begin
      x.is_err = 1'b0;
      x.v      = part;
      exp_q.push_back(x);
      cnt = 0;
    end
  endfunction

  task automatic tick(input bit v, input logic [11:0] dv, input bit fs);
    din_valid = v;
    din       = dv;
    din_first = fs;
    if (v && rst_n) model(dv, fs);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int q = 0; q < n; q++) tick(1'b0, 12'd0, 1'b0);
  endtask

  task automatic frame(input logic [11:0] s0, s1, s2, s3, input int gap);
    tick(1'b1, s0, 1'b1); idle(gap);
    tick(1'b1, s1, 1'b0); idle(gap);
    tick(1'b1, s2, 1'b0); idle(gap);
    tick(1'b1, s3, 1'b0);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    din_valid  = 1'b0;
    cnt        = 0;
    last_pub   = '0;
    exp_errcnt = 0;
    exp_q.delete();
    #1;
    chk("reset_outs", 144'(outs), 144'd0);
    chk("reset_pulses", 144'({frame_strobe, frame_error}), 144'd0);
`ifdef CHANNEL_DEMUX_ERR_COUNT_EN
    chk("reset_errcnt", 144'(err_count), 144'd0);
`endif
    idle(2);
    rst_n = 1'b1;
  endtask

  // monitor: pops one expected event per strobe/error pulse; otherwise outputs must hold
  always @(negedge clk) begin
    exp_t x;
    if (frame_strobe || frame_error)
      chk("pulse_excl", 144'(frame_strobe & frame_error), 144'd0);
    if (frame_error) begin
      if (exp_q.size() == 0) chk("unexpected_error", 144'd1, 144'd0);
      else begin
        x = exp_q.pop_front();
        chk("error_kind", 144'(x.is_err), 144'd1);
      end
      if (exp_errcnt < 255) exp_errcnt++;
`ifdef CHANNEL_DEMUX_ERR_COUNT_EN
      chk("err_count", 144'(err_count), 144'(exp_errcnt));
`endif
    end
    if (frame_strobe) begin
      if (exp_q.size() == 0) chk("unexpected_strobe", 144'd1, 144'd0);
      else begin
        x = exp_q.pop_front();
        chk("strobe_kind", 144'(x.is_err), 144'd0);
        chk("frame_data", 144'(outs), 144'(x.v));
        last_pub = x.v;
      end
    end else begin
      chk("hold", 144'(outs), 144'(last_pub));
    end
  end

  initial begin
    rst_n     = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    din_first = 1'b0;
    #1;
    do_reset();

    // back-to-back frame, then gapped frame
    frame(12'd100, -12'sd200, 12'd300, -12'sd400, 0);
    idle(2);
    frame(12'd11, -12'sd22, 12'd33, -12'sd44, 3);
    idle(2);

    // short frame then a good one
    tick(1'b1, 12'd5, 1'b1);
    tick(1'b1, 12'd6, 1'b0);
    frame(12'd7, 12'd8, 12'd9, 12'd10, 0);
    idle(2);

    // long frame: fifth sample is an error
    frame(12'd1, 12'd2, 12'd3, 12'd4, 0);
    tick(1'b1, 12'd5, 1'b0);
    idle(2);

    // extreme values pass bit-exact
    frame(-12'sd2048, 12'sd2047, -12'sd1, 12'd0, 1);
    idle(2);

    // reset mid-frame, then unsynced samples, then a full frame
    tick(1'b1, 12'd50, 1'b1);
    tick(1'b1, 12'd51, 1'b0);
    do_reset();
    tick(1'b1, 12'd52, 1'b0);
    tick(1'b1, 12'd53, 1'b0);
    frame(12'd60, 12'd61, 12'd62, 12'd63, 0);
    idle(2);

    // stray samples drive the error counter into saturation
    for (int q = 0; q < 300; q++) tick(1'b1, 12'($urandom), 1'b0);
    idle(2);

    // random traffic
    for (int q = 0; q < 1500; q++) begin
      if ($urandom_range(0, 9) < 7)
        tick(1'b1, 12'($urandom), ($urandom_range(0, 4) == 0));
      else
        tick(1'b0, 12'($urandom), 1'b0);
    end
    idle(4);

    chk("queue_drained", 144'(exp_q.size()), 144'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
